// File: rtl/fib_stream.sv
// Fibonacci stream generator: LANES consecutive terms per valid/ready beat, programmable seeds/count.
// Optional FIB_SAT_EN: tainted (overflowed) terms are emitted as all ones instead of wrapping.
module fib_stream #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       seed_a,
    input  logic [WIDTH-1:0]       seed_b,
    input  logic [CNT_W-1:0]       count,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_lane_valid,
    output logic                   out_last,
    output logic                   done,
    output logic                   overflow
);

    localparam int unsigned NT = LANES + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               ta_q, ta_d, tb_q, tb_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   term  [NT];
    logic               taint [NT];
    logic [LANES-1:0]   lane_mask;
    logic               last_beat;
    logic               xfer;
    logic               lane_ovf;

    // Term chain: t(j+2) = t(j) + t(j+1); taint follows carries and tainted operands.
    always_comb begin
        logic [WIDTH:0] sum_w;
        sum_w    = '0;
        term[0]  = a_q;
        taint[0] = ta_q;
        term[1]  = b_q;
        taint[1] = tb_q;
        for (int j = 2; j < int'(NT); j++) begin
            sum_w    = {1'b0, term[j-2]} + {1'b0, term[j-1]};
            term[j]  = sum_w[WIDTH-1:0];
            taint[j] = sum_w[WIDTH] | taint[j-2] | taint[j-1];
        end
    end

    assign last_beat = (rem_q <= CNT_W'(LANES));
    assign xfer      = (state_q == RUN) && out_ready;

    always_comb begin
        lane_mask = '0;
        lane_ovf  = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_mask[i] = !last_beat || (CNT_W'(i) < rem_q);
            lane_ovf     = lane_ovf | (lane_mask[i] & taint[i]);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ta_d    = ta_q;
        tb_d    = tb_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (count != '0) begin
                        a_d     = seed_a;
                        b_d     = seed_b;
                        ta_d    = 1'b0;
                        tb_d    = 1'b0;
                        rem_d   = count;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    a_d   = term[LANES];
                    b_d   = term[LANES+1];
                    ta_d  = taint[LANES];
                    tb_d  = taint[LANES+1];
                    rem_d = rem_q - CNT_W'(LANES);
                    if (lane_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ta_q    <= 1'b0;
            tb_q    <= 1'b0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy           = (state_q == RUN);
    assign out_valid      = (state_q == RUN);
    assign out_last       = (state_q == RUN) && last_beat;
    assign out_lane_valid = (state_q == RUN) ? lane_mask : '0;
    assign done           = done_q;
    assign overflow       = ovf_q;

    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
`ifdef FIB_SAT_EN
            out_data[i*WIDTH +: WIDTH] = taint[i] ? '1 : term[i];
`else
            out_data[i*WIDTH +: WIDTH] = term[i];
`endif
        end
    end

endmodule
